// File: rtl/pipeline_control_pkg.sv
// pipeline_control_pkg
//   Shared definitions for the pipeline stall/flush sequencer: reset level,
//   stage indices, FSM state encoding and the per-stage stall/bubble patterns.
//   No ports.
package pipeline_control_pkg;

    localparam logic RESET_ENABLE = 1'b1;

    localparam int STAGE_IF  = 0;
    localparam int STAGE_ID  = 1;
    localparam int STAGE_EX  = 2;
    localparam int STAGE_MEM = 3;

    typedef enum logic [1:0] {
        STATE_RUN     = 2'd0,
        STATE_PENDING = 2'd1,
        STATE_FLUSH   = 2'd2
    } state_t;

    // Freeze the requesting stage's latch and everything upstream of it,
    // and load a NOP into the latch just downstream of it.
    localparam logic [4:0] STALL_NONE  = 5'b00000;
    localparam logic [4:0] STALL_IF    = 5'b00001;
    localparam logic [4:0] STALL_ID    = 5'b00011;
    localparam logic [4:0] STALL_EX    = 5'b00111;
    localparam logic [4:0] STALL_MEM   = 5'b01111;

    localparam logic [3:0] BUBBLE_NONE = 4'b0000;
    localparam logic [3:0] BUBBLE_IF   = 4'b0001;
    localparam logic [3:0] BUBBLE_ID   = 4'b0010;
    localparam logic [3:0] BUBBLE_EX   = 4'b0100;
    localparam logic [3:0] BUBBLE_MEM  = 4'b1000;

endpackage

// File: rtl/pipeline_control_stall_priority_encoder.sv
// stall_priority_encoder
//   Combinational deepest-stage-wins mapping of stage stall requests to the
//   per-latch stall and bubble vectors.
//   request : [0]=IF, [1]=ID, [2]=EX, [3]=MEM stall requests
//   stall   : [0]=PC, [1]=IF/ID, [2]=ID/EX, [3]=EX/MEM, [4]=MEM/WB freeze
//   bubble  : [0]=IF/ID, [1]=ID/EX, [2]=EX/MEM, [3]=MEM/WB load-NOP
module stall_priority_encoder
    import pipeline_control_pkg::*;
(
    input  logic [3:0] request,
    output logic [4:0] stall,
    output logic [3:0] bubble
);

    always_comb begin
        stall  = STALL_NONE;
        bubble = BUBBLE_NONE;
        if (request[STAGE_MEM]) begin
            stall  = STALL_MEM;
            bubble = BUBBLE_MEM;
        end else if (request[STAGE_EX]) begin
            stall  = STALL_EX;
            bubble = BUBBLE_EX;
        end else if (request[STAGE_ID]) begin
            stall  = STALL_ID;
            bubble = BUBBLE_ID;
        end else if (request[STAGE_IF]) begin
            stall  = STALL_IF;
            bubble = BUBBLE_IF;
        end
    end

endmodule

// File: rtl/pipeline_control.sv
// pipeline_control
//   Central stall/flush sequencer for the five-stage pipeline. Resolves stage
//   stall requests, sequences exception/eret redirects (deferred behind an
//   in-flight MEM access) and keeps stall/flush performance counters.
//   clock, reset                     : clock, synchronous active-high reset
//   *_stall_request                  : per-stage stall requests
//   mem_exception_valid/_handler_... : exception in MEM and its vector
//   mem_eret, cp0_epc                : eret in MEM and its return address
//   stall, bubble                    : per-latch freeze / load-NOP controls
//   flush, pc_redirect_valid/_address: one-cycle redirect and latch clear
//   stall_cycle_count, flush_count   : performance counters
//
//   state   | meaning
//   RUN     | normal flow, accepting exceptions/eret
//   PENDING | redirect target latched, waiting for MEM stall to clear
//   FLUSH   | one cycle: clear latches and redirect the PC
module pipeline_control
    import pipeline_control_pkg::*;
#(
    parameter int STALL_COUNT_WIDTH = 32,
    parameter int FLUSH_COUNT_WIDTH = 16
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         if_stall_request,
    input  logic                         id_stall_request,
    input  logic                         ex_stall_request,
    input  logic                         mem_stall_request,
    input  logic                         mem_exception_valid,
    input  logic [31:0]                  mem_exception_handler_address,
    input  logic                         mem_eret,
    input  logic [31:0]                  cp0_epc,
    output logic [4:0]                   stall,
    output logic [3:0]                   bubble,
    output logic                         flush,
    output logic                         pc_redirect_valid,
    output logic [31:0]                  pc_redirect_address,
    output logic [STALL_COUNT_WIDTH-1:0] stall_cycle_count,
    output logic [FLUSH_COUNT_WIDTH-1:0] flush_count
);

    localparam logic [STALL_COUNT_WIDTH-1:0] STALL_COUNT_ONE = 1;
    localparam logic [FLUSH_COUNT_WIDTH-1:0] FLUSH_COUNT_ONE = 1;

    state_t                         state_q, state_d;
    logic [31:0]                    target_q, target_d;
    logic [STALL_COUNT_WIDTH-1:0]   stall_count_q, stall_count_d;
    logic [FLUSH_COUNT_WIDTH-1:0]   flush_count_q, flush_count_d;
    logic [4:0]                     enc_stall;
    logic [3:0]                     enc_bubble;
    logic                           redirect_request;

    stall_priority_encoder u_stall_priority_encoder (
        .request ({mem_stall_request, ex_stall_request,
                   id_stall_request, if_stall_request}),
        .stall   (enc_stall),
        .bubble  (enc_bubble)
    );

    assign redirect_request = mem_exception_valid | mem_eret;

    always_comb begin
        state_d             = state_q;
        target_d            = target_q;
        stall               = enc_stall;
        bubble              = enc_bubble;
        flush               = 1'b0;
        pc_redirect_valid   = 1'b0;
        pc_redirect_address = 32'h0;

        case (state_q)
            STATE_RUN: begin
                if (redirect_request) begin
                    target_d = mem_exception_valid ? mem_exception_handler_address
                                                   : cp0_epc;
                    if (mem_stall_request) begin
                        state_d = STATE_PENDING;
                    end else begin
                        // Freeze upstream and kill the faulting instruction's write-back.
                        stall   = STALL_MEM;
                        bubble  = BUBBLE_MEM;
                        state_d = STATE_FLUSH;
                    end
                end
            end
            STATE_PENDING: begin
                if (!mem_stall_request) begin
                    stall   = STALL_MEM;
                    bubble  = BUBBLE_MEM;
                    state_d = STATE_FLUSH;
                end
            end
            STATE_FLUSH: begin
                // Latches clear at the end of this cycle, so any request is moot.
                stall               = STALL_NONE;
                bubble              = BUBBLE_NONE;
                flush               = 1'b1;
                pc_redirect_valid   = 1'b1;
                pc_redirect_address = target_q;
                state_d             = STATE_RUN;
            end
            default: begin
                state_d = STATE_RUN;
            end
        endcase

        if (reset == RESET_ENABLE) begin
            stall               = STALL_NONE;
            bubble              = BUBBLE_NONE;
            flush               = 1'b0;
            pc_redirect_valid   = 1'b0;
            pc_redirect_address = 32'h0;
            state_d             = STATE_RUN;
            target_d            = 32'h0;
        end
    end

    always_comb begin
        stall_count_d = stall_count_q;
        flush_count_d = flush_count_q;
        if (stall != STALL_NONE) begin
            stall_count_d = stall_count_q + STALL_COUNT_ONE;
        end
        if ((state_d == STATE_FLUSH) && (state_q != STATE_FLUSH) && !(&flush_count_q)) begin
            flush_count_d = flush_count_q + FLUSH_COUNT_ONE;
        end
    end

    always_ff @(posedge clock) begin
        if (reset == RESET_ENABLE) begin
            state_q       <= STATE_RUN;
            target_q      <= 32'h0;
            stall_count_q <= '0;
            flush_count_q <= '0;
        end else begin
            state_q       <= state_d;
            target_q      <= target_d;
            stall_count_q <= stall_count_d;
            flush_count_q <= flush_count_d;
        end
    end

    always_comb begin
        stall_cycle_count = reset ? '0 : stall_count_q;
        flush_count       = reset ? '0 : flush_count_q;
    end

endmodule

// File: tb/tb_pipeline_control.sv
// tb_pipeline_control
//   Directed-vector bench for pipeline_control. A second, narrow-counter
//   instance shares the stimulus to reach counter wrap and saturation quickly.
module tb_pipeline_control;

    logic        clock = 1'b0;
    logic        reset;
    logic        if_req, id_req, ex_req, mem_req;
    logic        exc_valid, eret;
    logic [31:0] handler, epc;

    logic [4:0]  stall;
    logic [3:0]  bubble;
    logic        flush, redir_valid;
    logic [31:0] redir_addr;
    logic [31:0] stall_cnt;
    logic [15:0] flush_cnt;

    logic [4:0]  n_stall;
    logic [3:0]  n_bubble;
    logic        n_flush, n_redir_valid;
    logic [31:0] n_redir_addr;
    logic [3:0]  n_stall_cnt;
    logic [1:0]  n_flush_cnt;

    int vectors = 0;
    int miscompares = 0;

    always #5 clock = ~clock;

    pipeline_control dut (
        .clock                         (clock),
        .reset                         (reset),
        .if_stall_request              (if_req),
        .id_stall_request              (id_req),
        .ex_stall_request              (ex_req),
        .mem_stall_request             (mem_req),
        .mem_exception_valid           (exc_valid),
        .mem_exception_handler_address (handler),
        .mem_eret                      (eret),
        .cp0_epc                       (epc),
        .stall                         (stall),
        .bubble                        (bubble),
        .flush                         (flush),
        .pc_redirect_valid             (redir_valid),
        .pc_redirect_address           (redir_addr),
        .stall_cycle_count             (stall_cnt),
        .flush_count                   (flush_cnt)
    );

    pipeline_control #(.STALL_COUNT_WIDTH(4), .FLUSH_COUNT_WIDTH(2)) dut_narrow (
        .clock                         (clock),
        .reset                         (reset),
        .if_stall_request              (if_req),
        .id_stall_request              (id_req),
        .ex_stall_request              (ex_req),
        .mem_stall_request             (mem_req),
        .mem_exception_valid           (exc_valid),
        .mem_exception_handler_address (handler),
        .mem_eret                      (eret),
        .cp0_epc                       (epc),
        .stall                         (n_stall),
        .bubble                        (n_bubble),
        .flush                         (n_flush),
        .pc_redirect_valid             (n_redir_valid),
        .pc_redirect_address           (n_redir_addr),
        .stall_cycle_count             (n_stall_cnt),
        .flush_count                   (n_flush_cnt)
    );

    task automatic check_vec(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Drive new inputs on the falling edge, then let combinational outputs settle.
    task automatic next_cycle();
        @(negedge clock);
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic set_req(input logic i_if, input logic i_id, input logic i_ex, input logic i_mem);
        if_req  = i_if;
        id_req  = i_id;
        ex_req  = i_ex;
        mem_req = i_mem;
    endtask

    task automatic set_exc(input logic v, input logic [31:0] h, input logic e, input logic [31:0] p);
        exc_valid = v;
        handler   = h;
        eret      = e;
        epc       = p;
    endtask

    task automatic check_ctl(input string tag, input logic [4:0] s, input logic [3:0] b,
                             input logic f, input logic [31:0] a);
        check_vec({tag, ".stall"},  64'(stall),       64'(s));
        check_vec({tag, ".bubble"}, 64'(bubble),      64'(b));
        check_vec({tag, ".flush"},  64'(flush),       64'(f));
        check_vec({tag, ".redir"},  64'(redir_valid), 64'(f));
        check_vec({tag, ".addr"},   64'(redir_addr),  64'(a));
    endtask

    initial begin
        // Reset with every input active.
        reset = 1'b1;
        set_req(1, 1, 1, 1);
        set_exc(1, 32'hDEAD_0020, 1, 32'hBEEF_0100);
        settle();
        check_ctl("rst0", 5'b0, 4'b0, 1'b0, 32'h0);
        next_cycle(); settle();
        check_ctl("rst1", 5'b0, 4'b0, 1'b0, 32'h0);
        check_vec("rst1.stall_cnt", 64'(stall_cnt), 64'd0);
        check_vec("rst1.flush_cnt", 64'(flush_cnt), 64'd0);

        next_cycle();
        reset = 1'b0;
        set_req(0, 0, 0, 0);
        set_exc(0, 32'h0, 0, 32'h0);
        settle();
        check_ctl("idle", 5'b0, 4'b0, 1'b0, 32'h0);
        check_vec("idle.stall_cnt", 64'(stall_cnt), 64'd0);

        // IF + ID for three cycles: ID wins.
        for (int i = 0; i < 3; i++) begin
            next_cycle(); set_req(1, 1, 0, 0); settle();
            check_ctl("ifid", 5'b00011, 4'b0010, 1'b0, 32'h0);
        end
        next_cycle(); set_req(0, 0, 0, 0); settle();
        check_vec("ifid.stall_cnt", 64'(stall_cnt), 64'd3);

        next_cycle(); set_req(0, 0, 1, 1); settle();
        check_ctl("exmem", 5'b01111, 4'b1000, 1'b0, 32'h0);
        next_cycle(); set_req(0, 1, 1, 0); settle();
        check_ctl("idex", 5'b00111, 4'b0100, 1'b0, 32'h0);
        next_cycle(); set_req(1, 0, 0, 0); settle();
        check_ctl("if", 5'b00001, 4'b0001, 1'b0, 32'h0);
        next_cycle(); set_req(0, 0, 0, 0); settle();
        check_vec("mix.stall_cnt", 64'(stall_cnt), 64'd6);

        // Exception in RUN, no MEM stall; held input and EX request during FLUSH ignored.
        next_cycle(); set_exc(1, 32'h0000_0020, 0, 32'h0); settle();
        check_ctl("exc.T", 5'b01111, 4'b1000, 1'b0, 32'h0);
        next_cycle(); set_req(0, 0, 1, 0); settle();
        check_ctl("exc.T1", 5'b0, 4'b0, 1'b1, 32'h0000_0020);
        next_cycle(); set_req(0, 0, 0, 0); set_exc(0, 32'h0, 0, 32'h0); settle();
        check_ctl("exc.T2", 5'b0, 4'b0, 1'b0, 32'h0);
        check_vec("exc.flush_cnt", 64'(flush_cnt), 64'd1);
        check_vec("exc.stall_cnt", 64'(stall_cnt), 64'd7);

        // Exception behind a 3-cycle MEM stall; later handler/epc changes ignored.
        next_cycle(); set_req(0, 0, 0, 1); set_exc(1, 32'h0000_0080, 0, 32'h0000_0111); settle();
        check_ctl("pend.P0", 5'b01111, 4'b1000, 1'b0, 32'h0);
        next_cycle(); set_exc(0, 32'h0000_0999, 0, 32'h0000_0222); settle();
        check_ctl("pend.P1", 5'b01111, 4'b1000, 1'b0, 32'h0);
        next_cycle(); set_exc(1, 32'h0000_0444, 1, 32'h0000_0333); settle();
        check_ctl("pend.P2", 5'b01111, 4'b1000, 1'b0, 32'h0);
        next_cycle(); set_req(0, 0, 0, 0); set_exc(0, 32'h0, 0, 32'h0000_0444); settle();
        check_ctl("pend.P3", 5'b01111, 4'b1000, 1'b0, 32'h0);
        next_cycle(); settle();
        check_ctl("pend.P4", 5'b0, 4'b0, 1'b1, 32'h0000_0080);
        next_cycle(); settle();
        check_ctl("pend.P5", 5'b0, 4'b0, 1'b0, 32'h0);
        check_vec("pend.flush_cnt", 64'(flush_cnt), 64'd2);

        // eret redirects to EPC.
        next_cycle(); set_exc(0, 32'h0, 1, 32'hBFC0_0100); settle();
        check_ctl("eret.E0", 5'b01111, 4'b1000, 1'b0, 32'h0);
        next_cycle(); set_exc(0, 32'h0, 0, 32'h0); settle();
        check_ctl("eret.E1", 5'b0, 4'b0, 1'b1, 32'hBFC0_0100);

        // Simultaneous exception and eret: exception wins.
        next_cycle(); set_exc(1, 32'h0000_0180, 1, 32'h0000_DEAD); settle();
        check_ctl("both.X0", 5'b01111, 4'b1000, 1'b0, 32'h0);
        next_cycle(); set_exc(0, 32'h0, 0, 32'h0); settle();
        check_ctl("both.X1", 5'b0, 4'b0, 1'b1, 32'h0000_0180);
        next_cycle(); settle();
        check_vec("both.flush_cnt", 64'(flush_cnt), 64'd4);
        check_vec("both.stall_cnt", 64'(stall_cnt), 64'd13);
        check_vec("narrow.flush_sat", 64'(n_flush_cnt), 64'd3);
        check_vec("narrow.stall_cnt", 64'(n_stall_cnt), 64'd13);

        // Reset while PENDING discards the redirect.
        next_cycle(); set_req(0, 0, 0, 1); set_exc(1, 32'h0000_0055, 0, 32'h0); settle();
        check_ctl("rstp.R0", 5'b01111, 4'b1000, 1'b0, 32'h0);
        next_cycle(); reset = 1'b1; set_exc(0, 32'h0, 0, 32'h0); settle();
        check_ctl("rstp.R1", 5'b0, 4'b0, 1'b0, 32'h0);
        next_cycle(); reset = 1'b0; set_req(0, 0, 0, 0); settle();
        check_ctl("rstp.R2", 5'b0, 4'b0, 1'b0, 32'h0);
        next_cycle(); settle();
        check_ctl("rstp.R3", 5'b0, 4'b0, 1'b0, 32'h0);
        check_vec("rstp.flush_cnt", 64'(flush_cnt), 64'd0);
        check_vec("rstp.stall_cnt", 64'(stall_cnt), 64'd0);

        // Narrow stall counter: 15 stall cycles reach all-ones, one more wraps.
        for (int i = 0; i < 15; i++) begin
            next_cycle(); set_req(0, 0, 0, 1); settle();
        end
        next_cycle(); set_req(0, 0, 0, 0); settle();
        check_vec("wrap.ones", 64'(n_stall_cnt), 64'hF);
        next_cycle(); set_req(1, 0, 0, 0); settle();
        next_cycle(); set_req(0, 0, 0, 0); settle();
        check_vec("wrap.zero", 64'(n_stall_cnt), 64'h0);
        check_vec("wrap.wide", 64'(stall_cnt), 64'd16);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
